// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: latches one retiring result, formats load data and hands it to the
// register file over a valid/ready handshake with a one-cycle CSR commit window.
module ysyx_25020037_wbu #(
    parameter int XLEN   = 32,
    parameter int CNT_WD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              wbu_ready,
    input  logic [XLEN-1:0]   exu_result,
    input  logic [XLEN-1:0]   load_data,
    input  logic [1:0]        mem_addr_lo,
    input  logic              load_en,
    input  logic [2:0]        load_funct3,
    input  logic              csr_sel,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic [XLEN-1:0]   csr_wdata,
    input  logic              rd_wen,
    input  logic              gpr_ready,
    output logic              wbu_valid,
    output logic              gpr_we,
    output logic [XLEN:0]     wu_to_gu_bus,
    output logic [XLEN-1:0]   csr_wcsr_data,
    output logic              inst_retire,
    output logic [CNT_WD-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   csr_wdata_q;
    logic              rd_wen_q;
    logic              retire_q;
    logic [CNT_WD-1:0] cnt_q;

    logic              accept;
    logic              busy;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_fmt;
    logic [XLEN-1:0]   wdata_sel;

    assign accept = lsu_valid && (state_q == IDLE);
    assign busy   = (state_q != IDLE);

    // Formatting happens before the latch so only the final write-back value is stored.
    assign ld_byte = load_data[{mem_addr_lo, 3'b000} +: 8];
    assign ld_half = load_data[{mem_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        load_fmt = load_data;
        case (load_funct3)
            3'b000:  load_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: load_fmt = load_data;
        endcase
    end

    always_comb begin
        wdata_sel = exu_result;
        if (load_en) begin
            wdata_sel = load_fmt;
        end else if (csr_sel) begin
            wdata_sel = csr_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu_valid) state_d = SEND;
            SEND:    if (gpr_ready) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers only load on accept and hold through SEND and COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q     <= '0;
            csr_wdata_q <= '0;
            rd_wen_q    <= 1'b0;
        end else if (accept) begin
            wdata_q     <= wdata_sel;
            csr_wdata_q <= csr_wdata;
            rd_wen_q    <= rd_wen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            retire_q <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                cnt_q <= cnt_q + CNT_WD'(1);
            end
        end
    end

    assign wbu_ready     = (state_q == IDLE);
    assign wbu_valid     = busy;
    assign gpr_we        = busy && rd_wen_q;
    assign wu_to_gu_bus  = busy ? {gpr_we, wdata_q} : '0;
    assign csr_wcsr_data = csr_wdata_q;
    assign inst_retire   = retire_q;
    assign retire_cnt    = cnt_q;

endmodule
